spi_link_arbiter: RTL and testbench

- Shares the single spi_master link between NCH line channels.
- Each channel has a receive word stream toward the CPU and a transmit word demand from the CPU.
- Buffers receive words per channel, tags them with a channel index, and schedules RX and TX-poll transactions round-robin.
- Drives the spi_master handshake (rx_data/rx_strobe/rx_accept, tx_request/tx_data/tx_strobe) on the fast clock. spi_master's SCK is derived from this clock, so its outputs are sampled directly, without synchronisers.

---
 rtl/spi_link_pkg.sv | 30 +++
 rtl/spi_rx_fifo.sv | 50 +++++
 rtl/spi_link_arbiter.sv | 161 ++++++++++++++++
 tb/tb_spi_link_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_link_pkg.sv
// Shared constants, FSM encoding and word-format helpers for the SPI link arbiter.
package spi_link_pkg;

  // Reserved low-status pattern marking a TX-poll word (before tag insertion).
  localparam logic [7:0]  STATUS_POLL = 8'hFF;
  // Word spi_master shifts out when nothing is offered.
  localparam logic [15:0] IDLE_WORD   = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RX_OFFER = 3'd1,
    ST_TX_OFFER = 3'd2,
    ST_TX_WAIT  = 3'd3,
    ST_TX_DONE  = 3'd4
  } link_state_e;

  // Overwrite the top ch_w status bits of a channel word with the channel index.
  function automatic logic [15:0] tag_word(input logic [15:0] w, input logic [7:0] ch,
                                           input int ch_w);
    logic [7:0] keep;
    keep = 8'hFF >> ch_w;
    return {(w[15:8] & keep) | (ch << (8 - ch_w)), w[7:0]};
  endfunction

  // Poll word: channel index above an all-ones low status field, zero data.
  function automatic logic [15:0] poll_word(input logic [7:0] ch, input int ch_w);
    return {(STATUS_POLL >> ch_w) | (ch << (8 - ch_w)), 8'h00};
  endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// Per-channel receive word FIFO: valid/ready push side, head/pop/empty read side.
module spi_rx_fifo
  import spi_link_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] push_data_i,
  input  logic        push_valid_i,
  output logic        push_ready_o,
  output logic [15:0] head_o,
  input  logic        pop_i,
  output logic        empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  // Ready depends only on the registered count, so a pop in the same clk on a
  // full FIFO does not open the push side until the following clk.
  assign push_ready_o = (count_q != (AW+1)'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign head_o       = mem_q[rd_ptr_q];
  assign do_push      = push_valid_i & push_ready_o;
  assign do_pop       = pop_i & ~empty_o;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/spi_link_arbiter.sv
// Shares one spi_master link between NCH channels: buffers tagged RX words and
// round-robins RX offers and TX polls over slots rx0, tx0, rx1, tx1, ...
//
// Handshake: a channel word moves when ch_rx_valid[c] and ch_rx_ready[c] are
// both high at a clk edge; toward spi_master a word is offered by rx_strobe and
// taken on the rising edge of rx_accept; a TX word arrives while tx_strobe is
// high and is forwarded as a single-clk ch_tx_valid pulse.
module spi_link_arbiter
  import spi_link_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int CH_W       = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [16*NCH-1:0] ch_rx_data,
  input  logic [NCH-1:0]    ch_rx_valid,
  output logic [NCH-1:0]    ch_rx_ready,
  input  logic [NCH-1:0]    ch_tx_req,
  output logic [15:0]       ch_tx_data,
  output logic [NCH-1:0]    ch_tx_valid,
  output logic [15:0]       rx_data,
  output logic              rx_strobe,
  input  logic              rx_accept,
  output logic              tx_request,
  input  logic [15:0]       tx_data,
  input  logic              tx_strobe,
  output logic              busy
);

  localparam int NSLOT = 2 * NCH;
  localparam int SW    = CH_W + 1;

  link_state_e    state_q, state_d;
  logic [SW-1:0]  ptr_q, ptr_d, grant_q, grant_d, win;
  logic           found, acc_prev_q, acc_rise;
  logic [NSLOT-1:0] pend;
  logic [15:0]    rx_data_q, rx_data_d, ch_tx_data_q, ch_tx_data_d;
  logic           rx_strobe_q, rx_strobe_d, tx_request_q, tx_request_d;
  logic [NCH-1:0] ch_tx_valid_q, ch_tx_valid_d, pop, empty;
  logic [15:0]    head [NCH];
  logic [CH_W-1:0] gch;

  assign gch      = grant_q[SW-1:1];
  assign acc_rise = rx_accept & ~acc_prev_q;

  for (genvar c = 0; c < NCH; c++) begin : g_fifo
    spi_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .push_data_i  (ch_rx_data[16*c +: 16]),
      .push_valid_i (ch_rx_valid[c]),
      .push_ready_o (ch_rx_ready[c]),
      .head_o       (head[c]),
      .pop_i        (pop[c]),
      .empty_o      (empty[c])
    );
  end

  // Round-robin search: first pending slot at or after the pointer, wrapping.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int c = 0; c < NCH; c++) begin
      pend[2*c]     = ~empty[c];
      pend[2*c + 1] = ch_tx_req[c];
    end
    for (int i = 0; i < NSLOT; i++) begin
      idx = (int'(ptr_q) + i) % NSLOT;
      if (!found && pend[idx]) begin
        found = 1'b1;
        win   = SW'(idx);
      end
    end
  end

  // State, pointer, grant and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      grant_q       <= '0;
      acc_prev_q    <= 1'b0;
      rx_data_q     <= IDLE_WORD;
      rx_strobe_q   <= 1'b0;
      tx_request_q  <= 1'b0;
      ch_tx_data_q  <= '0;
      ch_tx_valid_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      acc_prev_q    <= rx_accept;
      rx_data_q     <= rx_data_d;
      rx_strobe_q   <= rx_strobe_d;
      tx_request_q  <= tx_request_d;
      ch_tx_data_q  <= ch_tx_data_d;
      ch_tx_valid_q <= ch_tx_valid_d;
    end
  end

  // Next-state logic: one word per grant, only accept rising edges advance.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: if (found) begin
        grant_d = win;
        ptr_d   = (win == SW'(NSLOT - 1)) ? '0 : win + 1'b1;
        state_d = win[0] ? ST_TX_OFFER : ST_RX_OFFER;
      end
      ST_RX_OFFER: if (acc_rise) state_d = ST_IDLE;
      ST_TX_OFFER: if (acc_rise) state_d = ST_TX_WAIT;
      ST_TX_WAIT:  if (tx_strobe) state_d = ST_TX_DONE;
      ST_TX_DONE:  if (!tx_strobe) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered link outputs and FIFO pops.
  always_comb begin
    rx_data_d     = IDLE_WORD;
    rx_strobe_d   = 1'b0;
    tx_request_d  = 1'b0;
    ch_tx_data_d  = ch_tx_data_q;
    ch_tx_valid_d = '0;
    pop           = '0;
    case (state_q)
      ST_RX_OFFER: begin
        rx_data_d   = tag_word(head[gch], 8'(gch), CH_W);
        rx_strobe_d = ~acc_rise;
        if (acc_rise) pop[gch] = 1'b1;
      end
      ST_TX_OFFER: begin
        rx_data_d    = poll_word(8'(gch), CH_W);
        rx_strobe_d  = ~acc_rise;
        tx_request_d = 1'b1;
      end
      ST_TX_WAIT: begin
        tx_request_d = ~tx_strobe;
        if (tx_strobe) begin
          ch_tx_data_d       = tx_data;
          ch_tx_valid_d[gch] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign rx_data     = rx_data_q;
  assign rx_strobe   = rx_strobe_q;
  assign tx_request  = tx_request_q;
  assign ch_tx_data  = ch_tx_data_q;
  assign ch_tx_valid = ch_tx_valid_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_link_arbiter.sv
// Bench for spi_link_arbiter with NCH=2: scoreboard of expected link words,
// spi_master-side responder tasks, and one task per scenario.
module tb_spi_link_arbiter;

  logic        clk, reset;
  logic [31:0] ch_rx_data;
  logic [1:0]  ch_rx_valid, ch_rx_ready, ch_tx_req, ch_tx_valid;
  logic [15:0] ch_tx_data, rx_data, tx_data;
  logic        rx_strobe, rx_accept, tx_request, tx_strobe, busy;

  logic [15:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  spi_link_arbiter #(.NCH(2), .CH_W(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .ch_rx_data(ch_rx_data), .ch_rx_valid(ch_rx_valid), .ch_rx_ready(ch_rx_ready),
    .ch_tx_req(ch_tx_req), .ch_tx_data(ch_tx_data), .ch_tx_valid(ch_tx_valid),
    .rx_data(rx_data), .rx_strobe(rx_strobe), .rx_accept(rx_accept),
    .tx_request(tx_request), .tx_data(tx_data), .tx_strobe(tx_strobe),
    .busy(busy)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  // Reference word formats for NCH=2 (one tag bit)
  function automatic logic [15:0] exp_tag(input int ch, input logic [15:0] w);
    logic c;
    c = ch[0];
    return {c, w[14:0]};
  endfunction

  function automatic logic [15:0] exp_poll(input int ch);
    logic c;
    c = ch[0];
    return {c, 7'h7F, 8'h00};
  endfunction

  function automatic logic [15:0] rand_word();
    logic [6:0] st;
    logic [7:0] d;
    st = 7'($urandom_range(0, 126));
    d  = 8'($urandom_range(0, 255));
    return {1'($urandom_range(0, 1)), st, d};
  endfunction

  // Driver tasks (all start and end on a negedge)
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push_word(input int ch, input logic [15:0] w, input bit record);
    int waited;
    waited = 0;
    ch_rx_data[16*ch +: 16] = w;
    ch_rx_valid[ch] = 1'b1;
    while (ch_rx_ready[ch] !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    n_vec++;
    if (ch_rx_ready[ch] !== 1'b1) begin
      n_miss++;
      $display("FAIL push_ready ch%0d ready=%b required=1", ch, ch_rx_ready[ch]);
      ch_rx_valid[ch] = 1'b0;
      return;
    end
    if (record) exp_q.push_back(exp_tag(ch, w));
    @(negedge clk);
    ch_rx_valid[ch] = 1'b0;
  endtask

  // spi_master model: wait for an offer, check it against the scoreboard, accept it.
  task automatic serve(output logic [15:0] got);
    int waited;
    logic [15:0] exp;
    waited = 0;
    got = 16'hFFFF;
    exp = 16'hFFFF;
    while (rx_strobe !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    n_vec++;
    if (rx_strobe !== 1'b1) begin
      n_miss++;
      $display("FAIL serve_timeout rx_strobe=%b required=1", rx_strobe);
      return;
    end
    got = rx_data;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_miss++;
      $display("FAIL serve_unexpected rx_data=%h required=none", rx_data);
    end else begin
      exp = exp_q.pop_front();
      if (rx_data !== exp) begin
        n_miss++;
        $display("FAIL serve_word rx_data=%h required=%h", rx_data, exp);
      end
    end
    n_vec++;
    if (tx_request !== (exp[14:8] == 7'h7F)) begin
      n_miss++;
      $display("FAIL serve_tx_request tx_request=%b required=%b", tx_request, exp[14:8] == 7'h7F);
    end
    rx_accept = 1'b1;
    @(negedge clk);
    n_vec++;
    if (rx_strobe !== 1'b0) begin
      n_miss++;
      $display("FAIL serve_strobe_drop rx_strobe=%b required=0", rx_strobe);
    end
    @(negedge clk);
    rx_accept = 1'b0;
  endtask

  // Completes a TX poll already accepted: deliver a word and release tx_strobe.
  task automatic tx_complete(input int ch, input logic [15:0] w);
    logic [1:0] onehot;
    onehot = 2'b00;
    onehot[ch] = 1'b1;
    n_vec++;
    if (tx_request !== 1'b1) begin
      n_miss++;
      $display("FAIL tx_wait_request tx_request=%b required=1", tx_request);
    end
    tx_data = w;
    tx_strobe = 1'b1;
    @(negedge clk);
    n_vec++;
    if (ch_tx_valid !== onehot || ch_tx_data !== w || tx_request !== 1'b0) begin
      n_miss++;
      $display("FAIL tx_deliver valid=%b data=%h txreq=%b required valid=%b data=%h txreq=0",
               ch_tx_valid, ch_tx_data, tx_request, onehot, w);
    end
    ch_tx_req[ch] = 1'b0;
    @(negedge clk);
    n_vec++;
    if (ch_tx_valid !== 2'b00 || busy !== 1'b1) begin
      n_miss++;
      $display("FAIL tx_pulse_done valid=%b busy=%b required valid=00 busy=1", ch_tx_valid, busy);
    end
    tx_strobe = 1'b0;
    @(negedge clk);
  endtask

  // Scenarios
  task automatic test_reset();
    do_reset();
    n_vec++;
    if (rx_strobe !== 1'b0 || tx_request !== 1'b0 || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_ctrl strobe=%b txreq=%b busy=%b required 0 0 0", rx_strobe, tx_request, busy);
    end
    n_vec++;
    if (rx_data !== 16'hFFFF) begin
      n_miss++;
      $display("FAIL reset_rx_data rx_data=%h required=ffff", rx_data);
    end
    n_vec++;
    if (ch_tx_valid !== 2'b00 || ch_tx_data !== 16'h0000) begin
      n_miss++;
      $display("FAIL reset_ch_tx valid=%b data=%h required 00 0000", ch_tx_valid, ch_tx_data);
    end
    n_vec++;
    if (ch_rx_ready !== 2'b11) begin
      n_miss++;
      $display("FAIL reset_ready ready=%b required=11", ch_rx_ready);
    end
  endtask

  task automatic test_single_rx();
    logic [15:0] got;
    ch_rx_data[31:16] = 16'h0341;
    ch_rx_valid[1] = 1'b1;
    @(negedge clk);
    ch_rx_valid[1] = 1'b0;
    exp_q.push_back(16'h8341);
    n_vec++;
    if (rx_strobe !== 1'b0) begin
      n_miss++;
      $display("FAIL single_lat0 rx_strobe=%b required=0", rx_strobe);
    end
    @(negedge clk);
    n_vec++;
    if (rx_strobe !== 1'b0) begin
      n_miss++;
      $display("FAIL single_lat1 rx_strobe=%b required=0", rx_strobe);
    end
    @(negedge clk);
    n_vec++;
    if (rx_strobe !== 1'b1 || rx_data !== 16'h8341) begin
      n_miss++;
      $display("FAIL single_lat2 rx_strobe=%b rx_data=%h required 1 8341", rx_strobe, rx_data);
    end
    serve(got);
    repeat (3) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || rx_strobe !== 1'b0 || ch_rx_ready[1] !== 1'b1) begin
      n_miss++;
      $display("FAIL single_empty busy=%b strobe=%b ready1=%b required 0 0 1", busy, rx_strobe, ch_rx_ready[1]);
    end
  endtask

  task automatic test_tx_flow();
    logic [15:0] got;
    ch_tx_req[0] = 1'b1;
    exp_q.push_back(16'h7F00);
    serve(got);
    tx_complete(0, 16'hA55A);
    n_vec++;
    if (busy !== 1'b0 || tx_request !== 1'b0) begin
      n_miss++;
      $display("FAIL tx_flow_idle busy=%b txreq=%b required 0 0", busy, tx_request);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] got, w0, w1, w2, wt;
    do_reset();
    w0 = 16'h1122;
    w1 = 16'h0455;
    ch_rx_data = {w1, w0};
    ch_rx_valid = 2'b11;
    @(negedge clk);
    ch_rx_valid = 2'b00;
    ch_tx_req[0] = 1'b1;
    exp_q.push_back(exp_tag(0, w0));
    exp_q.push_back(exp_poll(0));
    exp_q.push_back(exp_tag(1, w1));
    serve(got);
    serve(got);
    wt = 16'($urandom_range(0, 65535));
    tx_complete(0, wt);
    // rx1 is about to be granted; tx1 and rx0 become pending behind it.
    w2 = rand_word();
    ch_rx_data[15:0] = w2;
    ch_rx_valid[0] = 1'b1;
    ch_tx_req[1] = 1'b1;
    exp_q.push_back(exp_poll(1));
    exp_q.push_back(exp_tag(0, w2));
    @(negedge clk);
    ch_rx_valid[0] = 1'b0;
    serve(got);
    serve(got);
    wt = 16'($urandom_range(0, 65535));
    tx_complete(1, wt);
    serve(got);
  endtask

  task automatic test_fifo_full();
    logic [15:0] got;
    for (int i = 0; i < 4; i++) push_word(0, rand_word(), 1'b1);
    n_vec++;
    if (ch_rx_ready[0] !== 1'b0) begin
      n_miss++;
      $display("FAIL fifo_full_ready ready0=%b required=0", ch_rx_ready[0]);
    end
    fork
      push_word(0, rand_word(), 1'b1);
      serve(got);
    join
    n_vec++;
    if (ch_rx_ready[0] !== 1'b0) begin
      n_miss++;
      $display("FAIL fifo_refill_ready ready0=%b required=0", ch_rx_ready[0]);
    end
    for (int i = 0; i < 4; i++) serve(got);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL fifo_drain left=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_held_accept();
    logic [15:0] exp;
    int waited;
    push_word(1, rand_word(), 1'b1);
    push_word(1, rand_word(), 1'b1);
    waited = 0;
    while (rx_strobe !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    exp = exp_q.pop_front();
    n_vec++;
    if (rx_strobe !== 1'b1 || rx_data !== exp) begin
      n_miss++;
      $display("FAIL held_first strobe=%b rx_data=%h required 1 %h", rx_strobe, rx_data, exp);
    end
    rx_accept = 1'b1;
    repeat (8) @(negedge clk);
    exp = exp_q.pop_front();
    n_vec++;
    if (rx_strobe !== 1'b1 || rx_data !== exp) begin
      n_miss++;
      $display("FAIL held_no_pop strobe=%b rx_data=%h required 1 %h", rx_strobe, rx_data, exp);
    end
    rx_accept = 1'b0;
    @(negedge clk);
    rx_accept = 1'b1;
    @(negedge clk);
    n_vec++;
    if (rx_strobe !== 1'b0) begin
      n_miss++;
      $display("FAIL held_second_pop rx_strobe=%b required=0", rx_strobe);
    end
    rx_accept = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || rx_strobe !== 1'b0) begin
      n_miss++;
      $display("FAIL held_empty busy=%b strobe=%b required 0 0", busy, rx_strobe);
    end
  endtask

  task automatic test_reset_tx_wait();
    logic [15:0] got;
    ch_tx_req[1] = 1'b1;
    exp_q.push_back(exp_poll(1));
    serve(got);
    for (int i = 0; i < 4; i++) push_word(0, rand_word(), 1'b0);
    n_vec++;
    if (tx_request !== 1'b1 || busy !== 1'b1 || ch_rx_ready[0] !== 1'b0) begin
      n_miss++;
      $display("FAIL pre_reset txreq=%b busy=%b ready0=%b required 1 1 0", tx_request, busy, ch_rx_ready[0]);
    end
    reset = 1'b1;
    ch_tx_req = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    n_vec++;
    if (tx_request !== 1'b0 || rx_strobe !== 1'b0 || busy !== 1'b0 || ch_rx_ready !== 2'b11) begin
      n_miss++;
      $display("FAIL reset_mid_tx txreq=%b strobe=%b busy=%b ready=%b required 0 0 0 11",
               tx_request, rx_strobe, busy, ch_rx_ready);
    end
    exp_q.delete();
  endtask

  initial begin
    reset       = 1'b1;
    ch_rx_data  = '0;
    ch_rx_valid = '0;
    ch_tx_req   = '0;
    rx_accept   = 1'b0;
    tx_data     = '0;
    tx_strobe   = 1'b0;
    test_reset();
    test_single_rx();
    test_tx_flow();
    test_round_robin();
    test_fifo_full();
    test_held_accept();
    test_reset_tx_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
